// File: rtl/prog_logic_unit_if.sv
// Bus bundle for prog_logic_unit: table-load channel, input-vector channel, result channel, status.
// Master drives requests (stimulus side); slave is the logic unit itself.
interface prog_logic_unit_if #(
  parameter int unsigned N_IN  = 5,
  parameter int unsigned CNT_W = 16
);
  logic             cfg_start;
  logic             cfg_valid;
  logic             cfg_bit;
  logic             cfg_ready;
  logic             cfg_done;
  logic             in_valid;
  logic [N_IN-1:0]  in_vec;
  logic             in_ready;
  logic             out_valid;
  logic             out_f;
  logic             out_ready;
  logic [CNT_W-1:0] ones_cnt;
  logic [1:0]       state_o;

  modport master (
    output cfg_start, cfg_valid, cfg_bit, in_valid, in_vec, out_ready,
    input  cfg_ready, cfg_done, in_ready, out_valid, out_f, ones_cnt, state_o
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_bit, in_valid, in_vec, out_ready,
    output cfg_ready, cfg_done, in_ready, out_valid, out_f, ones_cnt, state_o
  );
endinterface

// File: rtl/prog_logic_unit.sv
// Programmable N_IN-input logic function: serially loaded truth table, 1-deep registered pipeline.
// Define PLU_DEFAULT_TABLE_EN to come out of reset in RUN with DEFAULT_TABLE already loaded.
module prog_logic_unit #(
  parameter int unsigned              N_IN          = 5,
  parameter int unsigned              CNT_W         = 16,
  parameter logic [(1 << N_IN)-1:0]   DEFAULT_TABLE = '0
) (
  input logic               clk,
  input logic               rst_n,
  prog_logic_unit_if.slave  bus
);

  localparam int unsigned      Depth   = 1 << N_IN;
  localparam logic [N_IN-1:0]  LastIdx = {N_IN{1'b1}};
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StLoad  = 2'b01,
    StRun   = 2'b10
  } state_e;

`ifdef PLU_DEFAULT_TABLE_EN
  localparam state_e           ResetState = StRun;
  localparam logic [Depth-1:0] ResetTable = DEFAULT_TABLE;
`else
  localparam state_e           ResetState = StEmpty;
  // DEFAULT_TABLE only matters when the reset-time table is enabled
  localparam logic [Depth-1:0] ResetTable = DEFAULT_TABLE & '0;
`endif

  state_e           r_state,     w_state_d;
  logic [Depth-1:0] r_table,     w_table_d;
  logic [N_IN-1:0]  r_load_idx,  w_load_idx_d;
  logic             r_out_valid, w_out_valid_d;
  logic             r_out_f,     w_out_f_d;
  logic             r_cfg_done,  w_cfg_done_d;
  logic [CNT_W-1:0] r_ones_cnt,  w_ones_cnt_d;
  logic             w_cfg_ready;
  logic             w_in_ready;
  logic             w_consume;

  always_comb begin
    w_state_d     = r_state;
    w_table_d     = r_table;
    w_load_idx_d  = r_load_idx;
    w_out_valid_d = r_out_valid;
    w_out_f_d     = r_out_f;
    w_cfg_done_d  = 1'b0;
    w_ones_cnt_d  = r_ones_cnt;
    w_cfg_ready   = 1'b0;
    w_in_ready    = 1'b0;
    w_consume     = r_out_valid & bus.out_ready;

    if (w_consume && r_out_f && (r_ones_cnt != CntMax)) begin
      w_ones_cnt_d = r_ones_cnt + CNT_W'(1);
    end

    case (r_state)
      StLoad: begin
        w_cfg_ready = 1'b1;
        if (bus.cfg_valid) begin
          w_table_d[r_load_idx] = bus.cfg_bit;
          if (r_load_idx == LastIdx) begin
            w_state_d    = StRun;
            w_load_idx_d = '0;
            w_cfg_done_d = 1'b1;
          end else begin
            w_load_idx_d = r_load_idx + N_IN'(1);
          end
        end
      end
      StRun: begin
        w_in_ready = ~bus.cfg_start & (~r_out_valid | bus.out_ready);
        // Reload waits for the pending result to drain so it is never lost
        if (bus.cfg_start && !r_out_valid) begin
          w_state_d    = StLoad;
          w_load_idx_d = '0;
          w_ones_cnt_d = '0;
        end
      end
      default: begin
        // Also covers the unused 2'b11 encoding
        if (bus.cfg_start) begin
          w_state_d    = StLoad;
          w_load_idx_d = '0;
          w_ones_cnt_d = '0;
        end
      end
    endcase

    if (w_in_ready && bus.in_valid) begin
      w_out_valid_d = 1'b1;
      w_out_f_d     = r_table[bus.in_vec];
    end else if (w_consume) begin
      w_out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ResetState;
      r_table     <= ResetTable;
      r_load_idx  <= '0;
      r_out_valid <= 1'b0;
      r_out_f     <= 1'b0;
      r_cfg_done  <= 1'b0;
      r_ones_cnt  <= '0;
    end else begin
      r_state     <= w_state_d;
      r_table     <= w_table_d;
      r_load_idx  <= w_load_idx_d;
      r_out_valid <= w_out_valid_d;
      r_out_f     <= w_out_f_d;
      r_cfg_done  <= w_cfg_done_d;
      r_ones_cnt  <= w_ones_cnt_d;
    end
  end

  assign bus.cfg_ready = w_cfg_ready;
  assign bus.cfg_done  = r_cfg_done;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_f     = r_out_f;
  assign bus.ones_cnt  = r_ones_cnt;
  assign bus.state_o   = r_state;

endmodule

// File: tb/tb_prog_logic_unit.sv
// Bench for prog_logic_unit: directed scenarios plus randomized traffic against a behavioural model.
// Two instances share stimulus: 16-bit counter and 2-bit counter (saturation).
module tb_prog_logic_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_logic_unit_if #(.N_IN(5), .CNT_W(16)) ifa ();
  prog_logic_unit_if #(.N_IN(5), .CNT_W(2))  ifb ();

  assign ifb.cfg_start = ifa.cfg_start;
  assign ifb.cfg_valid = ifa.cfg_valid;
  assign ifb.cfg_bit   = ifa.cfg_bit;
  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.in_vec    = ifa.in_vec;
  assign ifb.out_ready = ifa.out_ready;

  prog_logic_unit #(.N_IN(5), .CNT_W(16), .DEFAULT_TABLE(32'h0000_0002)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  prog_logic_unit #(.N_IN(5), .CNT_W(2), .DEFAULT_TABLE(32'h0000_0002)) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

`ifdef PLU_DEFAULT_TABLE_EN
  localparam int ResetMode = 2;
`else
  localparam int ResetMode = 0;
`endif

  int total = 0;
  int bad   = 0;
  int done_pulses = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 empty, 1 load, 2 run; m_ones counts ones without a ceiling
  int        m_mode;
  bit [31:0] m_tab;
  int        m_idx;
  bit        m_ov, m_f, m_done;
  int        m_ones;
  bit        m_acc, m_cons;

  function automatic bit exp_in_ready();
    return (m_mode == 2) && !ifa.cfg_start && (!m_ov || ifa.out_ready);
  endfunction

  task automatic model_reset();
`ifdef PLU_DEFAULT_TABLE_EN
    m_mode = 2;
    m_tab  = 32'h0000_0002;
`else
    m_mode = 0;
    m_tab  = '0;
`endif
    m_idx  = 0;
    m_ov   = 0;
    m_f    = 0;
    m_done = 0;
    m_ones = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_acc  = exp_in_ready() && ifa.in_valid;
      m_cons = m_ov && ifa.out_ready;
      if (m_cons && m_f) m_ones++;
      m_done = 0;
      if (m_mode == 1) begin
        if (ifa.cfg_valid) begin
          m_tab[m_idx] = ifa.cfg_bit;
          if (m_idx == 31) begin
            m_mode = 2;
            m_idx  = 0;
            m_done = 1;
          end else begin
            m_idx++;
          end
        end
      end else if (m_mode == 2) begin
        if (ifa.cfg_start && !m_ov) begin
          m_mode = 1;
          m_idx  = 0;
          m_ones = 0;
        end
      end else if (ifa.cfg_start) begin
        m_mode = 1;
        m_idx  = 0;
        m_ones = 0;
      end
      if (m_acc) begin
        m_ov = 1;
        m_f  = m_tab[ifa.in_vec];
      end else if (m_cons) begin
        m_ov = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("state", ifa.state_o, m_mode);
    chk("cfg_ready", ifa.cfg_ready, m_mode == 1);
    chk("in_ready", ifa.in_ready, exp_in_ready());
    chk("cfg_done", ifa.cfg_done, m_done);
    chk("out_valid", ifa.out_valid, m_ov);
    chk("out_f", ifa.out_f, m_f);
    chk("ones_cnt16", ifa.ones_cnt, (m_ones > 65535) ? 65535 : m_ones);
    chk("ones_cnt2", ifb.ones_cnt, (m_ones > 3) ? 3 : m_ones);
    chk("sat_out_f", ifb.out_f, m_f);
    chk("sat_state", ifb.state_o, m_mode);
    if (ifa.cfg_done) done_pulses++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bits(input logic [31:0] bits, input int nbits);
    int n = 0;
    int i = 0;
    ifa.cfg_start = 1'b1;
    while (ifa.state_o != 2'b01 && n < 100) begin
      cyc();
      n++;
    end
    if (n >= 100) chk("load_enter", ifa.state_o, 1);
    ifa.cfg_start = 1'b0;
    while (i < nbits) begin
      ifa.cfg_valid = ($urandom_range(0, 2) != 0);
      ifa.cfg_bit   = bits[i];
      if (ifa.cfg_valid) i++;
      cyc();
    end
    ifa.cfg_valid = 1'b0;
  endtask

  logic [4:0] t2_vec [4];
  logic       t2_exp [4];

  initial begin
    model_reset();
    ifa.cfg_start = 0;
    ifa.cfg_valid = 0;
    ifa.cfg_bit   = 0;
    ifa.in_valid  = 0;
    ifa.in_vec    = '0;
    ifa.out_ready = 0;
    t2_vec = '{5'b00000, 5'b00111, 5'b11101, 5'b11111};
    t2_exp = '{1'b1, 1'b0, 1'b0, 1'b1};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

`ifndef PLU_DEFAULT_TABLE_EN
    // T1: empty unit ignores inputs
    ifa.in_valid = 1'b1;
    ifa.in_vec   = 5'h03;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t1_in_ready", ifa.in_ready, 0);
      chk("t1_out_valid", ifa.out_valid, 0);
      chk("t1_state", ifa.state_o, 0);
    end
    ifa.in_valid = 1'b0;
`else
    ifa.in_valid = 1'b1;
    ifa.in_vec   = 5'b00001;
    cyc();
    ifa.in_valid = 1'b0;
    chk("dflt_out_valid", ifa.out_valid, 1);
    chk("dflt_out_f", ifa.out_f, 1);
    ifa.out_ready = 1'b1;
    cyc();
    ifa.out_ready = 1'b0;
`endif

    // T2: table 0x8000_0001, back-to-back vectors
    done_pulses = 0;
    load_bits(32'h8000_0001, 32);
    repeat (3) cyc();
    chk("t2_done_pulses", done_pulses, 1);
    chk("t2_state_run", ifa.state_o, 2);
    ifa.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ifa.in_valid = 1'b1;
      ifa.in_vec   = t2_vec[k];
      cyc();
      chk("t2_out_valid", ifa.out_valid, 1);
      chk("t2_out_f", ifa.out_f, t2_exp[k]);
    end
    ifa.in_valid = 1'b0;
    cyc();
    chk("t2_ones_cnt", ifa.ones_cnt, 2);

    // T3: backpressure holds result and blocks input
    ifa.in_valid = 1'b1;
    ifa.in_vec   = 5'b11111;
    cyc();
    ifa.out_ready = 1'b0;
    ifa.in_vec    = 5'b00111;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t3_hold_valid", ifa.out_valid, 1);
      chk("t3_hold_f", ifa.out_f, 1);
      chk("t3_in_ready", ifa.in_ready, 0);
    end
    ifa.out_ready = 1'b1;
    cyc();
    chk("t3_next_f", ifa.out_f, 0);
    ifa.in_vec = 5'b00000;
    cyc();
    chk("t3_last_f", ifa.out_f, 1);
    ifa.in_valid = 1'b0;
    cyc();
    chk("t3_drained", ifa.out_valid, 0);

    // T4: reload request waits for pending result
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_vec    = 5'b11111;
    cyc();
    ifa.in_valid  = 1'b0;
    ifa.cfg_start = 1'b1;
    repeat (3) begin
      cyc();
      chk("t4_state_hold", ifa.state_o, 2);
      chk("t4_pending", ifa.out_valid, 1);
    end
    ifa.out_ready = 1'b1;
    cyc();
    chk("t4_state_drain", ifa.state_o, 2);
    chk("t4_consumed", ifa.out_valid, 0);
    cyc();
    chk("t4_state_load", ifa.state_o, 1);
    chk("t4_cnt_clear", ifa.ones_cnt, 0);
    ifa.cfg_start = 1'b0;

    // T5: reset mid-load discards the partial table
    load_bits(32'hFFFF_0000, 17);
    rst_n = 1'b0;
    #1;
    chk("t5_reset_state", ifa.state_o, ResetMode);
    @(posedge clk);
    #1 rst_n = 1'b1;
    load_bits(32'hFFFF_0000, 32);
    ifa.in_valid = 1'b1;
    ifa.in_vec   = 5'b10000;
    cyc();
    ifa.in_valid = 1'b0;
    chk("t5_out_f", ifa.out_f, 1);

    // T6: saturation of the 2-bit counter
    load_bits(32'hFFFF_FFFF, 32);
    ifa.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ifa.in_valid = 1'b1;
      ifa.in_vec   = 5'($urandom);
      cyc();
    end
    ifa.in_valid = 1'b0;
    cyc();
    chk("t6_cnt2_sat", ifb.ones_cnt, 3);
    chk("t6_cnt16", ifa.ones_cnt, 6);

    // Randomized traffic, including reloads and a reset mid-stream
    for (int k = 0; k < 1500; k++) begin
      ifa.cfg_start = ($urandom_range(0, 29) == 0);
      ifa.cfg_valid = $urandom_range(0, 1) != 0;
      ifa.cfg_bit   = $urandom_range(0, 1) != 0;
      ifa.in_valid  = $urandom_range(0, 2) != 0;
      ifa.in_vec    = 5'($urandom);
      ifa.out_ready = $urandom_range(0, 3) != 0;
      if (k == 700) rst_n = 1'b0;
      if (k == 702) rst_n = 1'b1;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
